// File: rtl/clock_sequencer.sv
// Programmable clock divider with run/halt/single-step control and one-cycle edge strobes.
// Optional period counter output enabled by defining CLKSEQ_PERIOD_CNT_EN.
//
// state     | meaning
// RUN       | free-running divided clock
// HALT_PEND | halt requested, finishing the current period
// HALTED    | clk_out parked low, ratio tracks div_ratio
// STEP      | running exactly one period, then back to HALTED
module clock_sequencer #(
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             halted,
    output logic [1:0]       state
`ifdef CLKSEQ_PERIOD_CNT_EN
    ,
    output logic [CNT_W-1:0] period_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2,
        STEP      = 2'd3
    } state_t;

    state_t           st;
    logic [DIV_W-1:0] ph;
    logic [DIV_W-1:0] n;
    logic [DIV_W-1:0] n_req;
    logic [DIV_W:0]   half;
    logic             wrap;

    // Ratios 0 and 1 cannot form a period with both a high and a low phase.
    assign n_req = (div_ratio < DIV_W'(2)) ? DIV_W'(2) : div_ratio;
    // One extra bit so N+1 cannot overflow at the maximum ratio.
    assign half  = ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
    assign wrap  = (ph == n - DIV_W'(1));
    assign state = st;

`ifndef CLKSEQ_PERIOD_CNT_EN
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= RUN;
            ph       <= '0;
            n        <= DIV_W'(DEFAULT_DIV);
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            halted   <= 1'b0;
`ifdef CLKSEQ_PERIOD_CNT_EN
            period_cnt <= '0;
`endif
        end else if (st == HALTED) begin
            ph       <= '0;
            n        <= n_req;
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            if (run_req) begin
                st     <= RUN;
                halted <= 1'b0;
            end else if (step_req) begin
                st     <= STEP;
                halted <= 1'b0;
            end
        end else begin
            clk_out  <= ({1'b0, ph} < half);
            rise_stb <= (ph == '0);
            fall_stb <= ({1'b0, ph} == half);
            if (wrap) begin
                ph <= '0;
                n  <= n_req;
`ifdef CLKSEQ_PERIOD_CNT_EN
                period_cnt <= period_cnt + CNT_W'(1);
`endif
            end else begin
                ph <= ph + DIV_W'(1);
            end
            case (st)
                RUN: begin
                    if (halt_req) st <= HALT_PEND;
                end
                HALT_PEND: begin
                    if (run_req) begin
                        st <= RUN;
                    end else if (wrap) begin
                        st     <= HALTED;
                        halted <= 1'b1;
                    end
                end
                STEP: begin
                    if (wrap) begin
                        st     <= HALTED;
                        halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_sequencer.sv
// Randomized bench for clock_sequencer against a period-position reference model.
module tb_clock_sequencer;

    localparam int DIV_W = 4;
    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] div_ratio;
    logic             run_req, halt_req, step_req;
    logic             clk_out, rise_stb, fall_stb, halted;
    logic [1:0]       state;
`ifdef CLKSEQ_PERIOD_CNT_EN
    logic [CNT_W-1:0] period_cnt;
`endif

    clock_sequencer #(.DIV_W(DIV_W), .DEFAULT_DIV(2), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .div_ratio (div_ratio),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .clk_out   (clk_out),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .halted    (halted),
        .state     (state)
`ifdef CLKSEQ_PERIOD_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: position within the current period plus the mode.
    // Modes: 0 run, 1 halt pending, 2 halted, 3 single step.
    int          m_mode, m_pos, m_n, m_cnt;
    bit          m_clk, m_rise, m_fall;

    function automatic int eff_ratio(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    task automatic model_edge();
        int  hi_len;
        bit  last;
        int  next_mode;
        if (reset) begin
            m_mode = 0; m_pos = 0; m_n = 2; m_cnt = 0;
            m_clk = 0; m_rise = 0; m_fall = 0;
            return;
        end
        if (m_mode == 2) begin
            m_pos = 0; m_clk = 0; m_rise = 0; m_fall = 0;
            m_n = eff_ratio(int'(div_ratio));
            if (run_req) m_mode = 0;
            else if (step_req) m_mode = 3;
            return;
        end
        hi_len = (m_n + 1) / 2;
        last   = (m_pos == m_n - 1);
        m_clk  = (m_pos < hi_len);
        m_rise = (m_pos == 0);
        m_fall = (m_pos == hi_len);
        next_mode = m_mode;
        if (m_mode == 0 && halt_req) next_mode = 1;
        else if (m_mode == 1 && run_req) next_mode = 0;
        else if ((m_mode == 1 || m_mode == 3) && last) next_mode = 2;
        m_mode = next_mode;
        m_pos = (m_pos + 1) % m_n;
        if (last) begin
            m_n = eff_ratio(int'(div_ratio));
            m_cnt++;
        end
    endtask

    task automatic compare_all(input string where);
        check_val({where, ":clk_out"},  32'(clk_out),  32'(m_clk));
        check_val({where, ":rise_stb"}, 32'(rise_stb), 32'(m_rise));
        check_val({where, ":fall_stb"}, 32'(fall_stb), 32'(m_fall));
        check_val({where, ":state"},    32'(state),    32'(m_mode));
        check_val({where, ":halted"},   32'(halted),   32'(m_mode == 2));
`ifdef CLKSEQ_PERIOD_CNT_EN
        check_val({where, ":period_cnt"}, period_cnt, 32'(m_cnt));
`endif
    endtask

    task automatic cycle(input string where);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(where);
        @(negedge clock);
    endtask

    int seen_halted = 0;
    int seen_step   = 0;

    initial begin
        reset = 1'b1; div_ratio = 4'd2;
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        @(negedge clock);
        cycle("reset");
        cycle("reset");
        reset = 1'b0;

        // Default ratio 2: 1,0,1,0 with rise on odd edges.
        for (int i = 0; i < 5; i++) cycle("div2");

        // Ratio change takes effect only at the period boundary.
        div_ratio = 4'd5;
        for (int i = 0; i < 12; i++) cycle("div5");
        div_ratio = 4'd0;
        for (int i = 0; i < 6; i++) cycle("div0");

        // Halt, then single steps at N=3.
        div_ratio = 4'd4;
        for (int i = 0; i < 4; i++) cycle("div4");
        halt_req = 1'b1;
        cycle("halt");
        halt_req = 1'b0;
        for (int i = 0; i < 6; i++) cycle("halting");
        div_ratio = 4'd3;
        step_req = 1'b1;
        cycle("step");
        step_req = 1'b0;
        for (int i = 0; i < 5; i++) cycle("stepping");

        // Reset in the middle of a step.
        step_req = 1'b1;
        cycle("step2");
        step_req = 1'b0;
        cycle("step2");
        cycle("step2");
        reset = 1'b1;
        cycle("rst_step");
        reset = 1'b0;
        cycle("after_rst");

        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            halt_req = ($urandom_range(0, 24) == 0);
            run_req  = ($urandom_range(0, 19) == 0);
            step_req = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 29) == 0) div_ratio = DIV_W'($urandom_range(0, 15));
            if (m_mode == 2) seen_halted++;
            if (m_mode == 3) seen_step++;
            cycle("rand");
        end
        check_val("coverage_halted", 32'(seen_halted > 0), 32'd1);
        check_val("coverage_step",   32'(seen_step > 0),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
